// File: rtl/dmem_pkg.sv
// dmem_pkg: shared definitions for the data-memory arbiter.
//   - RV32I load/store funct3 width codes
//   - arbiter FSM state enum
package dmem_pkg;

    localparam int F3_W = 3;

    // Store width codes
    localparam logic [F3_W-1:0] SB  = 3'b000;
    localparam logic [F3_W-1:0] SH  = 3'b001;
    localparam logic [F3_W-1:0] SW  = 3'b010;

    // Load width codes
    localparam logic [F3_W-1:0] LB  = 3'b000;
    localparam logic [F3_W-1:0] LH  = 3'b001;
    localparam logic [F3_W-1:0] LW  = 3'b010;
    localparam logic [F3_W-1:0] LBU = 3'b100;
    localparam logic [F3_W-1:0] LHU = 3'b101;

    // ARB   : both ports compete, round-robin on last grant
    // LOCK1 : port 1 owns the memory exclusively
    typedef enum logic {
        ARB   = 1'b0,
        LOCK1 = 1'b1
    } arb_state_e;

endpackage

// File: rtl/dmem_arbiter_if.sv
// dmem_arbiter_if: request/response/memory bundle of the data-memory arbiter.
//   req0_* : core LSU request port        rsp0_* : its response
//   req1_* : debug/DMA request port       rsp1_* : its response
//   mem_*  : forwarded access towards the data memory (mem_rdata comes back)
// modport slave  : the arbiter side
// modport master : the requester/memory side
//
// Handshake: a request is accepted in a cycle where reqN_valid and reqN_ready
// are both 1. reqN_ready is only raised for the cycle's winner, so a requester
// must hold its request stable until it sees ready. Every accepted request gets
// exactly one rspN_valid pulse in the following cycle; there is no rsp backpressure.
interface dmem_arbiter_if;
    import dmem_pkg::*;

    logic            req0_valid;
    logic            req0_ready;
    logic            req0_write;
    logic [31:0]     req0_addr;
    logic [31:0]     req0_wdata;
    logic [F3_W-1:0] req0_funct3;

    logic            req1_valid;
    logic            req1_ready;
    logic            req1_write;
    logic [31:0]     req1_addr;
    logic [31:0]     req1_wdata;
    logic [F3_W-1:0] req1_funct3;
    logic            req1_lock;

    logic            rsp0_valid;
    logic [31:0]     rsp0_rdata;
    logic            rsp0_err;
    logic            rsp1_valid;
    logic [31:0]     rsp1_rdata;
    logic            rsp1_err;

    logic            mem_write;
    logic [31:0]     mem_addr;
    logic [31:0]     mem_wdata;
    logic [F3_W-1:0] mem_funct3;
    logic [31:0]     mem_rdata;

    modport slave (
        input  req0_valid, req0_write, req0_addr, req0_wdata, req0_funct3,
        input  req1_valid, req1_write, req1_addr, req1_wdata, req1_funct3, req1_lock,
        output req0_ready, req1_ready,
        output rsp0_valid, rsp0_rdata, rsp0_err,
        output rsp1_valid, rsp1_rdata, rsp1_err,
        output mem_write, mem_addr, mem_wdata, mem_funct3,
        input  mem_rdata
    );

    modport master (
        output req0_valid, req0_write, req0_addr, req0_wdata, req0_funct3,
        output req1_valid, req1_write, req1_addr, req1_wdata, req1_funct3, req1_lock,
        input  req0_ready, req1_ready,
        input  rsp0_valid, rsp0_rdata, rsp0_err,
        input  rsp1_valid, rsp1_rdata, rsp1_err,
        input  mem_write, mem_addr, mem_wdata, mem_funct3,
        output mem_rdata
    );

endinterface

// File: rtl/dmem_access_check.sv
// dmem_access_check: combinational legality check of one memory access.
//   addr   in  32  byte address
//   funct3 in  3   RV32I load/store width code
//   write  in  1   1 = store, 0 = load
//   err    out 1   access is misaligned, out of range or uses an illegal funct3
module dmem_access_check
    import dmem_pkg::*;
#(
    parameter int ADDR_BYTES = 4096
) (
    input  logic [31:0]     addr,
    input  logic [F3_W-1:0] funct3,
    input  logic            write,
    output logic            err
);

    logic code_ok;
    logic align_ok;
    logic range_ok;

    always_comb begin
        if (write) begin
            code_ok = (funct3 == SB) || (funct3 == SH) || (funct3 == SW);
        end else begin
            code_ok = (funct3 == LB) || (funct3 == LH) || (funct3 == LW) ||
                      (funct3 == LBU) || (funct3 == LHU);
        end

        // funct3[1:0] encodes the access size for every legal code
        case (funct3[1:0])
            2'b01:   align_ok = ~addr[0];
            2'b10:   align_ok = (addr[1:0] == 2'b00);
            default: align_ok = 1'b1;
        endcase

        range_ok = (addr < 32'(ADDR_BYTES));
        err      = ~(code_ok & align_ok & range_ok);
    end

endmodule

// File: rtl/dmem_arbiter.sv
// dmem_arbiter: two-port arbiter in front of a single-ported data memory.
//   clk      in   clock, rising edge
//   rst      in   asynchronous active-low reset
//   bus      slave modport of dmem_arbiter_if (request ports, responses, memory)
//   state_o  out  current FSM state (ARB / LOCK1)
// Port 0 is the core LSU, port 1 the debug/DMA port. Arbitration is
// combinational round-robin; port 1 may lock the memory for a bounded number
// of cycles. Responses return exactly one cycle after acceptance.
module dmem_arbiter
    import dmem_pkg::*;
#(
    parameter int ADDR_BYTES = 4096,
    parameter int LOCK_MAX   = 16
) (
    input  logic         clk,
    input  logic         rst,
    dmem_arbiter_if.slave bus,
    output arb_state_e   state_o
);

    localparam int                CNT_W    = (LOCK_MAX > 2) ? $clog2(LOCK_MAX) : 1;
    localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(LOCK_MAX - 1);

    arb_state_e       state_q, state_d;
    logic             last_grant_q, last_grant_d;
    logic [CNT_W-1:0] lock_cnt_q, lock_cnt_d;
    logic [CNT_W-1:0] cnt_inc;

    logic             elig0;
    logic             grant0, grant1, any_grant;
    logic             sel_write;
    logic [31:0]      sel_addr, sel_wdata;
    logic [F3_W-1:0]  sel_funct3;
    logic             chk_err;
    logic [31:0]      load_data;

    logic             rsp0_valid_q, rsp0_err_q;
    logic             rsp1_valid_q, rsp1_err_q;
    logic [31:0]      rsp0_rdata_q, rsp1_rdata_q;

    // last_grant_q = 1 means port 1 won last, so port 0 wins a contest.
    always_comb begin
        elig0     = bus.req0_valid && (state_q == ARB);
        grant0    = elig0 && (!bus.req1_valid || last_grant_q);
        grant1    = bus.req1_valid && (!elig0 || !last_grant_q);
        any_grant = grant0 || grant1;
    end

    always_comb begin
        sel_write  = 1'b0;
        sel_addr   = '0;
        sel_wdata  = '0;
        sel_funct3 = '0;
        if (grant0) begin
            sel_write  = bus.req0_write;
            sel_addr   = bus.req0_addr;
            sel_wdata  = bus.req0_wdata;
            sel_funct3 = bus.req0_funct3;
        end else if (grant1) begin
            sel_write  = bus.req1_write;
            sel_addr   = bus.req1_addr;
            sel_wdata  = bus.req1_wdata;
            sel_funct3 = bus.req1_funct3;
        end
    end

    dmem_access_check #(
        .ADDR_BYTES (ADDR_BYTES)
    ) u_check (
        .addr   (sel_addr),
        .funct3 (sel_funct3),
        .write  (sel_write),
        .err    (chk_err)
    );

    assign bus.req0_ready = grant0;
    assign bus.req1_ready = grant1;
    assign bus.mem_write  = any_grant && sel_write && !chk_err;
    assign bus.mem_addr   = sel_addr;
    assign bus.mem_wdata  = sel_wdata;
    assign bus.mem_funct3 = sel_funct3;

    assign load_data = (any_grant && !sel_write && !chk_err) ? bus.mem_rdata : '0;

    // The cycle that takes the lock counts as the first held cycle, so LOCK1
    // is left once the incremented count reaches LOCK_MAX-1: port 1 then has
    // held the memory for LOCK_MAX consecutive cycles.
    always_comb begin
        state_d      = state_q;
        lock_cnt_d   = lock_cnt_q;
        last_grant_d = last_grant_q;
        cnt_inc      = lock_cnt_q + 1'b1;

        if (any_grant) begin
            last_grant_d = grant1;
        end

        case (state_q)
            ARB: begin
                if (grant1 && bus.req1_lock) begin
                    state_d    = LOCK1;
                    lock_cnt_d = '0;
                end
            end
            LOCK1: begin
                lock_cnt_d = cnt_inc;
                if (!bus.req1_lock) begin
                    state_d    = ARB;
                    lock_cnt_d = '0;
                end else if (cnt_inc == CNT_LAST) begin
                    // Timeout: hand the next contest to port 0.
                    state_d      = ARB;
                    lock_cnt_d   = '0;
                    last_grant_d = 1'b1;
                end
            end
            default: begin
                state_d    = ARB;
                lock_cnt_d = '0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q      <= ARB;
            last_grant_q <= 1'b1;
            lock_cnt_q   <= '0;
        end else begin
            state_q      <= state_d;
            last_grant_q <= last_grant_d;
            lock_cnt_q   <= lock_cnt_d;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rsp0_valid_q <= 1'b0;
            rsp0_err_q   <= 1'b0;
            rsp0_rdata_q <= '0;
            rsp1_valid_q <= 1'b0;
            rsp1_err_q   <= 1'b0;
            rsp1_rdata_q <= '0;
        end else begin
            rsp0_valid_q <= grant0;
            rsp0_err_q   <= grant0 && chk_err;
            rsp0_rdata_q <= grant0 ? load_data : '0;
            rsp1_valid_q <= grant1;
            rsp1_err_q   <= grant1 && chk_err;
            rsp1_rdata_q <= grant1 ? load_data : '0;
        end
    end

    assign bus.rsp0_valid = rsp0_valid_q;
    assign bus.rsp0_err   = rsp0_err_q;
    assign bus.rsp0_rdata = rsp0_rdata_q;
    assign bus.rsp1_valid = rsp1_valid_q;
    assign bus.rsp1_err   = rsp1_err_q;
    assign bus.rsp1_rdata = rsp1_rdata_q;
    assign state_o        = state_q;

endmodule

// File: tb/tb_dmem_arbiter.sv
// tb_dmem_arbiter: randomized + directed bench for dmem_arbiter with a
// byte-array memory, a behavioural reference model and a response scoreboard.
module tb_dmem_arbiter;
  import dmem_pkg::*;

  localparam int ADDR_BYTES = 4096;
  localparam int LOCK_MAX   = 16;

  typedef struct {
    logic        valid;
    logic        write;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [2:0]  f3;
  } req_t;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  dmem_arbiter_if bus();
  arb_state_e     state;

  dmem_arbiter #(.ADDR_BYTES(ADDR_BYTES), .LOCK_MAX(LOCK_MAX)) dut (
    .clk     (clk),
    .rst     (rst),
    .bus     (bus),
    .state_o (state)
  );

  // ---------------- memory attached to mem_* ----------------
  logic [7:0]  tb_mem [ADDR_BYTES];
  logic        mem_clear = 1'b1;
  logic [11:0] wa;
  logic [31:0] rd_raw;

  function automatic logic [31:0] ext(input logic [31:0] raw, input logic [2:0] f3);
    case (f3)
      3'b000:  return {{24{raw[7]}}, raw[7:0]};
      3'b001:  return {{16{raw[15]}}, raw[15:0]};
      3'b010:  return raw;
      3'b100:  return {24'h0, raw[7:0]};
      3'b101:  return {16'h0, raw[15:0]};
      default: return 32'h0;
    endcase
  endfunction

  assign wa = bus.mem_addr[11:0];

  always_comb begin
    rd_raw        = {tb_mem[wa + 12'd3], tb_mem[wa + 12'd2], tb_mem[wa + 12'd1], tb_mem[wa]};
    bus.mem_rdata = ext(rd_raw, bus.mem_funct3);
  end

  always @(posedge clk) begin
    if (mem_clear) begin
      for (int i = 0; i < ADDR_BYTES; i++) tb_mem[i] <= 8'h00;
    end else if (bus.mem_write) begin
      tb_mem[wa] <= bus.mem_wdata[7:0];
      if (bus.mem_funct3[1:0] != 2'b00) tb_mem[wa + 12'd1] <= bus.mem_wdata[15:8];
      if (bus.mem_funct3[1:0] == 2'b10) begin
        tb_mem[wa + 12'd2] <= bus.mem_wdata[23:16];
        tb_mem[wa + 12'd3] <= bus.mem_wdata[31:24];
      end
    end
  end

  // ---------------- reference model ----------------
  logic [7:0] ref_mem [ADDR_BYTES];
  int         m_lg;      // port that won the most recent grant
  bit         m_locked;  // port 1 currently owns the memory
  int         m_age;     // cycles the current lock has been held

  function automatic bit model_err(input logic w, input logic [31:0] a, input logic [2:0] f);
    bit legal;
    int size;
    if (w) legal = (f == 3'd0) || (f == 3'd1) || (f == 3'd2);
    else   legal = (f == 3'd0) || (f == 3'd1) || (f == 3'd2) || (f == 3'd4) || (f == 3'd5);
    size = 1 << f[1:0];
    return !legal || (a >= 32'(ADDR_BYTES)) || ((a % size) != 0);
  endfunction

  function automatic logic [31:0] ref_load(input logic [31:0] a, input logic [2:0] f);
    int base;
    logic [31:0] raw;
    base = int'(a[11:0]);
    raw = 32'h0;
    for (int k = 0; k < 4; k++) raw[8*k +: 8] = ref_mem[(base + k) % ADDR_BYTES];
    return ext(raw, f);
  endfunction

  task automatic ref_store(input logic [31:0] a, input logic [31:0] d, input logic [2:0] f);
    int size;
    size = 1 << f[1:0];
    for (int k = 0; k < size; k++) ref_mem[int'(a[11:0]) + k] = d[8*k +: 8];
  endtask

  // ---------------- scoreboard ----------------
  logic [32:0] exp_q0[$];
  logic [32:0] exp_q1[$];
  int n_checks = 0;
  int n_pass   = 0;
  int obs;  // DUT grant seen in the last driven cycle: -1 none, 0, 1

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
  endtask

  // ---------------- driver ----------------
  function automatic req_t idle_req();
    req_t r;
    r.valid = 1'b0; r.write = 1'b0; r.addr = 32'h0; r.wdata = 32'h0; r.f3 = 3'h0;
    return r;
  endfunction

  function automatic req_t mk_req(input logic w, input logic [31:0] a,
                                  input logic [31:0] d, input logic [2:0] f);
    req_t r;
    r.valid = 1'b1; r.write = w; r.addr = a; r.wdata = d; r.f3 = f;
    return r;
  endfunction

  function automatic req_t rand_req();
    req_t r;
    int   pick;
    r.valid = ($urandom_range(0, 3) != 0);
    r.write = $urandom_range(0, 1);
    r.wdata = $urandom;
    pick = $urandom_range(0, 9);
    if (pick < 8)       r.addr = $urandom_range(0, 63);
    else if (pick == 8) r.addr = ADDR_BYTES - 4 + $urandom_range(0, 3);
    else                r.addr = ADDR_BYTES + $urandom_range(0, 100);
    pick = $urandom_range(0, 9);
    if (pick == 0)    r.f3 = $urandom_range(0, 7);
    else if (r.write) r.f3 = $urandom_range(0, 2);
    else begin
      pick = $urandom_range(0, 4);
      r.f3 = (pick < 3) ? 3'(pick) : 3'(pick + 1);
    end
    return r;
  endfunction

  task automatic cycle(input req_t r0, input req_t r1, input logic lk);
    int   g;
    bit   e;
    req_t w;
    logic [31:0] rdata;
    @(negedge clk);
    bus.req0_valid = r0.valid; bus.req0_write = r0.write; bus.req0_addr = r0.addr;
    bus.req0_wdata = r0.wdata; bus.req0_funct3 = r0.f3;
    bus.req1_valid = r1.valid; bus.req1_write = r1.write; bus.req1_addr = r1.addr;
    bus.req1_wdata = r1.wdata; bus.req1_funct3 = r1.f3;
    bus.req1_lock  = lk;
    #1;
    obs = bus.req1_ready ? 1 : (bus.req0_ready ? 0 : -1);

    if (m_locked)               g = r1.valid ? 1 : -1;
    else if (r0.valid && r1.valid) g = (m_lg == 1) ? 0 : 1;
    else if (r0.valid)          g = 0;
    else if (r1.valid)          g = 1;
    else                        g = -1;

    check("state", {31'h0, state == LOCK1}, {31'h0, m_locked});
    check("req0_ready", {31'h0, bus.req0_ready}, {31'h0, g == 0});
    check("req1_ready", {31'h0, bus.req1_ready}, {31'h0, g == 1});

    if (g >= 0) begin
      w = (g == 0) ? r0 : r1;
      e = model_err(w.write, w.addr, w.f3);
      check("mem_write", {31'h0, bus.mem_write}, {31'h0, w.write && !e});
      check("mem_addr", bus.mem_addr, w.addr);
      check("mem_funct3", {29'h0, bus.mem_funct3}, {29'h0, w.f3});
      if (w.write && !e) check("mem_wdata", bus.mem_wdata, w.wdata);
      rdata = (!w.write && !e) ? ref_load(w.addr, w.f3) : 32'h0;
      if (w.write && !e) ref_store(w.addr, w.wdata, w.f3);
      if (g == 0) exp_q0.push_back({e, rdata});
      else        exp_q1.push_back({e, rdata});
      m_lg = g;
    end else begin
      check("idle_mem_write", {31'h0, bus.mem_write}, 32'h0);
      check("idle_mem_addr", bus.mem_addr, 32'h0);
    end

    if (m_locked) begin
      if (!lk) m_locked = 0;
      else begin
        m_age++;
        if (m_age >= LOCK_MAX) begin
          m_locked = 0;
          m_lg = 1;
        end
      end
    end else if (g == 1 && lk) begin
      m_locked = 1;
      m_age = 1;
    end
  endtask

  task automatic model_reset();
    m_lg = 1;
    m_locked = 0;
    m_age = 0;
    exp_q0.delete();
    exp_q1.delete();
  endtask

  // ---------------- monitor ----------------
  always @(posedge clk) begin : monitor
    logic [32:0] e;
    #1;
    if (bus.rsp0_valid || exp_q0.size() != 0) begin
      check("rsp0_valid", {31'h0, bus.rsp0_valid}, {31'h0, exp_q0.size() != 0});
      if (bus.rsp0_valid && exp_q0.size() != 0) begin
        e = exp_q0.pop_front();
        check("rsp0_rdata", bus.rsp0_rdata, e[31:0]);
        check("rsp0_err", {31'h0, bus.rsp0_err}, {31'h0, e[32]});
      end else if (exp_q0.size() != 0) begin
        e = exp_q0.pop_front();
      end
    end
    if (bus.rsp1_valid || exp_q1.size() != 0) begin
      check("rsp1_valid", {31'h0, bus.rsp1_valid}, {31'h0, exp_q1.size() != 0});
      if (bus.rsp1_valid && exp_q1.size() != 0) begin
        e = exp_q1.pop_front();
        check("rsp1_rdata", bus.rsp1_rdata, e[31:0]);
        check("rsp1_err", {31'h0, bus.rsp1_err}, {31'h0, e[32]});
      end else if (exp_q1.size() != 0) begin
        e = exp_q1.pop_front();
      end
    end
  end

  // ---------------- stimulus ----------------
  initial begin
    int   seq[48];
    int   start;
    int   run;
    logic lk;

    for (int i = 0; i < ADDR_BYTES; i++) ref_mem[i] = 8'h00;
    model_reset();
    bus.req0_valid = 1'b0; bus.req0_write = 1'b0; bus.req0_addr = '0;
    bus.req0_wdata = '0; bus.req0_funct3 = '0;
    bus.req1_valid = 1'b0; bus.req1_write = 1'b0; bus.req1_addr = '0;
    bus.req1_wdata = '0; bus.req1_funct3 = '0; bus.req1_lock = 1'b0;

    repeat (2) @(negedge clk);
    check("reset_rsp0_valid", {31'h0, bus.rsp0_valid}, 32'h0);
    check("reset_rsp1_valid", {31'h0, bus.rsp1_valid}, 32'h0);
    check("reset_rsp0_rdata", bus.rsp0_rdata, 32'h0);
    check("reset_state", {31'h0, state == LOCK1}, 32'h0);
    mem_clear = 1'b0;
    rst = 1'b1;

    // Both ports contend every cycle: grants alternate starting with port 0.
    for (int i = 0; i < 8; i++) begin
      cycle(mk_req(1'b0, 32'h20, 32'h0, LW), mk_req(1'b0, 32'h24, 32'h0, LW), 1'b0);
      check("alternate_grant", obs, i % 2);
    end

    // Store then load through port 0.
    cycle(mk_req(1'b1, 32'h10, 32'hDEADBEEF, SW), idle_req(), 1'b0);
    cycle(mk_req(1'b0, 32'h10, 32'h0, LW), idle_req(), 1'b0);

    // Misaligned halfword load on port 1, then a clean word load.
    cycle(idle_req(), mk_req(1'b0, 32'h13, 32'h0, LH), 1'b0);
    cycle(idle_req(), mk_req(1'b0, 32'h10, 32'h0, LW), 1'b0);

    // Out-of-range byte store must leave memory untouched.
    cycle(mk_req(1'b0, 32'h0, 32'h0, LW), idle_req(), 1'b0);
    cycle(mk_req(1'b1, 32'd4096, 32'h000000AA, SB), idle_req(), 1'b0);
    cycle(mk_req(1'b0, 32'h0, 32'h0, LW), idle_req(), 1'b0);

    // Port 1 holds the lock while port 0 keeps asking.
    cycle(idle_req(), idle_req(), 1'b0);
    for (int i = 0; i < 48; i++) begin
      cycle(mk_req(1'b0, 32'h8, 32'h0, LW), mk_req(1'b0, 32'hC, 32'h0, LW), 1'b1);
      seq[i] = obs;
    end
    start = -1;
    for (int i = 0; i < 48; i++) if (start < 0 && seq[i] == 1) start = i;
    run = 0;
    if (start >= 0) while (start + run < 48 && seq[start + run] == 1) run++;
    check("lock_run_len", run, LOCK_MAX);
    check("after_lock_port0", (start >= 0 && start + run < 48) ? seq[start + run] : -1, 0);
    cycle(idle_req(), idle_req(), 1'b0);

    // Random traffic with bursty lock requests.
    lk = 1'b0;
    for (int i = 0; i < 2000; i++) begin
      if ($urandom_range(0, 7) == 0) lk = ~lk;
      cycle(rand_req(), rand_req(), lk);
    end
    cycle(idle_req(), idle_req(), 1'b0);
    cycle(idle_req(), idle_req(), 1'b0);

    // Reset right after a load is accepted: its response must vanish.
    cycle(mk_req(1'b0, 32'h10, 32'h0, LW), idle_req(), 1'b0);
    rst = 1'b0;
    model_reset();
    bus.req0_valid = 1'b0;
    bus.req1_valid = 1'b0;
    #1;
    check("rst_rsp0_valid", {31'h0, bus.rsp0_valid}, 32'h0);
    check("rst_rsp0_rdata", bus.rsp0_rdata, 32'h0);
    check("rst_state", {31'h0, state == LOCK1}, 32'h0);
    repeat (2) @(negedge clk);
    rst = 1'b1;
    cycle(idle_req(), idle_req(), 1'b0);
    cycle(mk_req(1'b0, 32'h10, 32'h0, LW), mk_req(1'b0, 32'h14, 32'h0, LW), 1'b0);
    check("post_reset_first_grant", obs, 0);
    cycle(idle_req(), idle_req(), 1'b0);
    cycle(idle_req(), idle_req(), 1'b0);

    check("exp_q0_drained", exp_q0.size(), 0);
    check("exp_q1_drained", exp_q1.size(), 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
